alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin controller that shares the single `ALU_Project` instance between `NREQ` requesters. It accepts one operation at a time, checks the opcode, drives the ALU `start`/`op`/`a`/`b` inputs, and waits for `done`. It then returns the 16-bit result, or an error, to the requester that issued the operation. It sits between the command sources and the ALU, and the ALU has no other driver.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `DATA_W`, default 8: operand width; the result is `2*DATA_W`.
- `TIMEOUT`, default 16: number of cycles after `alu_start` that the block waits for `alu_done` before reporting an error.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  NREQ: per-requester request level.
- `req_op`  in  NREQ*3: packed opcodes; requester i uses bits [3i+2:3i].
- `req_a`, `req_b`  in  NREQ*DATA_W each: packed operands.
- `gnt`  out  NREQ: one-hot, one-cycle acceptance pulse.
- `rsp_valid`  out  NREQ: one-hot, one-cycle response pulse.
- `rsp_result`  out  2*DATA_W: result, valid with `rsp_valid`.
- `rsp_err`  out  1: error flag, valid with `rsp_valid`; set for an illegal opcode or a timeout.
- `alu_start`  out  1; `alu_op`  out  3; `alu_a`, `alu_b`  out  DATA_W: ALU command.
- `alu_done`  in  1; `alu_result`  in  2*DATA_W: ALU completion.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, some `req` bit high:**
  - Pick the winner round-robin, starting from the index after the last granted one.
  - Latch its op, a and b.
  - Pulse `gnt[i]`.
  - Legal op (000..101): assert `alu_start` and go to WAIT.
  - Illegal op (110, 111): do not start the ALU; go to RESP with `rsp_err=1` and result 0.
- **WAIT:**
  - `alu_op/a/b` hold the latched values for the whole state.
  - `alu_done` is ignored in the `alu_start` cycle. From the next cycle on, the first sampled `alu_done=1` latches `alu_result` and moves to RESP with `rsp_err=0`.
  - A cycle counter clears at `alu_start` and increments each WAIT cycle while `alu_done` is low. If it reaches `TIMEOUT`, go to RESP with `rsp_err=1` and result 0.
  - If `alu_done` and the timeout fall in the same cycle, `alu_done` wins.
- **RESP:** pulse `rsp_valid[i]` for the latched winner, drive `rsp_result`/`rsp_err`, then return to IDLE.
- The round-robin pointer updates only when a grant is issued.
- `req` is not sampled outside IDLE.
- Requester rules:
  - Hold `req` and the operands stable until `gnt`.
  - Drop `req` after `gnt` unless another operation is wanted.
  - A `req` still high on return to IDLE counts as a new request.
- `alu_done` arriving in IDLE or RESP, for example a late pulse after a timeout, is ignored.

## Timing
- Reset (asynchronous) forces:
  - state IDLE;
  - all outputs 0: `gnt`, `rsp_valid`, `rsp_result`, `rsp_err`, `alu_start`, `alu_op`, `alu_a`, `alu_b`, `busy`;
  - the pointer set so that requester 0 has first priority;
  - counter 0.
- Reset in WAIT abandons the operation; no response is issued.
- All outputs are registered. Let `req` be sampled at edge T, and let the ALU assert `alu_done` k cycles after `start` (k≥1):
  - `gnt` and `alu_start` are high in cycle T+1;
  - `rsp_valid` is high in cycle T+2+k.
- Illegal op: `gnt` at T+1, `rsp_valid` at T+2.
- Timeout: `rsp_valid` at T+2+`TIMEOUT`.
- Back-to-back: the earliest next `gnt` is 2 cycles after a `rsp_valid` (one IDLE cycle to sample, one to grant).
- `busy` is high from the `gnt` cycle through the `rsp_valid` cycle inclusive.

## Structure
- Package `alu_arb_pkg`:
  - state enum {IDLE, WAIT, RESP};
  - opcode constants OP_0..OP_5 = 3'b000..3'b101 and OP_MAX = 3'b101;
  - default `DATA_W`=8.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `req[NREQ-1:0]` and `last[$clog2(NREQ)-1:0]`, and outputs a one-hot `pick` and its index. The FSM, latches and counter stay in `alu_arbiter`.

## Test plan
- Single request: requester 0, op=000, a=2, b=5; ALU model returns done 3 cycles after start with result 16'h0007. Required: `gnt[0]` at T+1, `alu_start` for one cycle, `rsp_valid[0]` at T+5 with result 0007 and err 0.
- Contention: both requesters hold `req` continuously with op=001, a=2, b=5. Required: grants alternate 0,1,0,1, and each `rsp_valid` goes only to the index just granted.
- Illegal op: requester 1 issues op=111. Required: `gnt[1]` at T+1, no `alu_start`, `rsp_valid[1]` at T+2 with err 1 and result 0.
- Timeout: the ALU model never asserts done, `TIMEOUT`=16. Required: `rsp_err=1` with result 0 at T+18. A stray done at T+20 is ignored, and the next request is serviced normally.
- Done/timeout tie: `alu_done` is asserted in exactly the `TIMEOUT`-th WAIT cycle with result 000A. Required: err 0 and result 000A.
- Reset in WAIT: assert `reset` 2 cycles after `alu_start`. Required: all outputs 0 immediately, no `rsp_valid` ever issued for that operation, and after release requester 0 wins when both request.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU round-robin arbiter.
// Opcodes above OP_MAX are rejected without starting the ALU.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_0   = 3'b000;
  localparam logic [2:0] OP_1   = 3'b001;
  localparam logic [2:0] OP_2   = 3'b010;
  localparam logic [2:0] OP_3   = 3'b011;
  localparam logic [2:0] OP_4   = 3'b100;
  localparam logic [2:0] OP_5   = 3'b101;
  localparam logic [2:0] OP_MAX = OP_5;

  localparam int DEF_DATA_W = 8;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; the environment (requesters + ALU) uses master.
interface alu_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = alu_arb_pkg::DEF_DATA_W
);

  logic [NREQ-1:0]        req;
  logic [NREQ*3-1:0]      req_op;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [2*DATA_W-1:0]    rsp_result;
  logic                   rsp_err;
  logic                   alu_start;
  logic [2:0]             alu_op;
  logic [DATA_W-1:0]      alu_a;
  logic [DATA_W-1:0]      alu_b;
  logic                   alu_done;
  logic [2*DATA_W-1:0]    alu_result;
  logic                   busy;
  alu_arb_pkg::state_t    dbg_state;

  // Handshake: a requester holds req and operands until its one-cycle gnt;
  // the single rsp_valid pulse later carries rsp_result/rsp_err for that requester.
  modport slave (
    input  req, req_op, req_a, req_b, alu_done, alu_result,
    output gnt, rsp_valid, rsp_result, rsp_err,
           alu_start, alu_op, alu_a, alu_b, busy, dbg_state
  );

  modport master (
    output req, req_op, req_a, req_b, alu_done, alu_result,
    input  gnt, rsp_valid, rsp_result, rsp_err,
           alu_start, alu_op, alu_a, alu_b, busy, dbg_state
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after index `last`, wrapping.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDXW = $clog2(NREQ);

  logic            found;
  logic [IDXW-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = last;
    idx   = '0;
    pick  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + IDXW'(1);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) pick = NREQ'(1) << idx;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, opcode check,
// ALU command/wait with timeout, and a one-cycle response to the granted requester.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int RW   = 2 * DATA_W;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]     rsp_result_q, rsp_result_d;
  logic              rsp_err_q, rsp_err_d;
  logic              alu_start_q, alu_start_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;

  logic [NREQ-1:0]   pick;
  logic [IDXW-1:0]   pick_idx;
  logic [NREQ-1:0]   win_onehot;

  logic [2:0]        op_arr [NREQ];
  logic [DATA_W-1:0] a_arr  [NREQ];
  logic [DATA_W-1:0] b_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[3*g +: 3];
    assign a_arr[g]  = bus.req_a[DATA_W*g +: DATA_W];
    assign b_arr[g]  = bus.req_b[DATA_W*g +: DATA_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign win_onehot = NREQ'(1) << win_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;
    alu_start_d  = 1'b0;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d    = pick_idx;
          last_d   = pick_idx;
          gnt_d    = pick;
          alu_op_d = op_arr[pick_idx];
          alu_a_d  = a_arr[pick_idx];
          alu_b_d  = b_arr[pick_idx];
          cnt_d    = '0;
          if (op_legal(op_arr[pick_idx])) begin
            alu_start_d = 1'b1;
            state_d     = WAIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // The start cycle neither samples done nor counts toward the timeout.
        if (alu_start_q) begin
          cnt_d = '0;
        end else if (bus.alu_done) begin
          rsp_valid_d  = win_onehot;
          rsp_result_d = bus.alu_result;
          state_d      = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d       = CW'(TIMEOUT);
          rsp_valid_d = win_onehot;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // Entered straight from IDLE on an illegal opcode: issue the error pulse now.
        if (|rsp_valid_q) begin
          state_d = IDLE;
        end else begin
          rsp_valid_d = win_onehot;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IDXW'(NREQ - 1);
      win_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      alu_start_q  <= alu_start_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two requesters plus a cycle-stepped ALU model
// that answers k cycles after alu_start (k = 0 means it never answers).
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  int          cd = 0;
  int          model_k = 0;
  logic [15:0] model_res = '0;

  alu_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  alu_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, then run the ALU model for that cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    bus.alu_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = model_res;
      end
    end
    if (bus.alu_start === 1'b1 && model_k > 0) cd = model_k;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.alu_done = 1'b0; bus.alu_result = '0;
    step(); step();
    vecs++; if (bus.gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
    vecs++; if (bus.rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    vecs++; if (bus.rsp_result !== 16'h0000) begin errs++; $display("FAIL reset_rsp_result: got %h expected 0000", bus.rsp_result); end
    vecs++; if (bus.rsp_err !== 1'b0) begin errs++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    vecs++; if (bus.alu_start !== 1'b0) begin errs++; $display("FAIL reset_alu_start: got %b expected 0", bus.alu_start); end
    vecs++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 19'h0) begin errs++; $display("FAIL reset_alu_cmd: got %h expected 0", {bus.alu_op, bus.alu_a, bus.alu_b}); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vecs++; if (bus.dbg_state !== IDLE) begin errs++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int starts = 0;
    bus.req_op = {3'b000, 3'b000}; bus.req_a = {8'd0, 8'd2}; bus.req_b = {8'd0, 8'd5};
    model_k = 3; model_res = 16'h0007;
    bus.req = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.alu_start === 1'b1) starts++;
      vecs++; if (bus.gnt !== (i == 1 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL single_gnt c%0d: got %b expected %b", i, bus.gnt, (i == 1 ? 2'b01 : 2'b00)); end
      vecs++; if (bus.rsp_valid !== (i == 5 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL single_rsp_valid c%0d: got %b expected %b", i, bus.rsp_valid, (i == 5 ? 2'b01 : 2'b00)); end
      vecs++; if (bus.busy !== (i <= 5)) begin errs++; $display("FAIL single_busy c%0d: got %b expected %b", i, bus.busy, (i <= 5)); end
      if (i == 3) begin
        vecs++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'd0, 8'd2, 8'd5}) begin errs++; $display("FAIL single_alu_cmd: got %h expected %h", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd0, 8'd2, 8'd5}); end
      end
      if (i == 5) begin
        vecs++; if (bus.rsp_result !== 16'h0007) begin errs++; $display("FAIL single_result: got %h expected 0007", bus.rsp_result); end
        vecs++; if (bus.rsp_err !== 1'b0) begin errs++; $display("FAIL single_err: got %b expected 0", bus.rsp_err); end
      end
      if (i == 1) bus.req = 2'b00;
    end
    vecs++; if (starts != 1) begin errs++; $display("FAIL single_start_cycles: got %0d expected 1", starts); end
  endtask

  task automatic test_illegal();
    int starts = 0;
    bus.req_op = {3'b111, 3'b000}; bus.req_a = {8'd9, 8'd0}; bus.req_b = {8'd9, 8'd0};
    model_k = 3;
    bus.req = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (bus.alu_start === 1'b1) starts++;
      vecs++; if (bus.gnt !== (i == 1 ? 2'b10 : 2'b00)) begin errs++; $display("FAIL illegal_gnt c%0d: got %b expected %b", i, bus.gnt, (i == 1 ? 2'b10 : 2'b00)); end
      vecs++; if (bus.rsp_valid !== (i == 2 ? 2'b10 : 2'b00)) begin errs++; $display("FAIL illegal_rsp_valid c%0d: got %b expected %b", i, bus.rsp_valid, (i == 2 ? 2'b10 : 2'b00)); end
      vecs++; if (bus.busy !== (i <= 2)) begin errs++; $display("FAIL illegal_busy c%0d: got %b expected %b", i, bus.busy, (i <= 2)); end
      if (i == 2) begin
        vecs++; if (bus.rsp_err !== 1'b1) begin errs++; $display("FAIL illegal_err: got %b expected 1", bus.rsp_err); end
        vecs++; if (bus.rsp_result !== 16'h0000) begin errs++; $display("FAIL illegal_result: got %h expected 0000", bus.rsp_result); end
      end
      if (i == 1) bus.req = 2'b00;
    end
    vecs++; if (starts != 0) begin errs++; $display("FAIL illegal_no_start: got %0d expected 0", starts); end
  endtask

  task automatic test_contention();
    int ngnt = 0;
    int nrsp = 0;
    int last_g = -1;
    int last_rsp_cyc = 0;
    int g;
    logic [1:0] exp_rv;
    bus.req_op = {3'b001, 3'b001}; bus.req_a = {8'd2, 8'd2}; bus.req_b = {8'd5, 8'd5};
    model_k = 2; model_res = 16'hFFFD;
    bus.req = 2'b11;
    for (int i = 0; i < 80 && nrsp < 4; i++) begin
      step();
      if (bus.gnt !== 2'b00) begin
        g = (bus.gnt === 2'b01) ? 0 : (bus.gnt === 2'b10) ? 1 : 9;
        vecs++; if (g != ngnt % 2) begin errs++; $display("FAIL contention_order grant%0d: got %b expected index %0d", ngnt, bus.gnt, ngnt % 2); end
        if (ngnt > 0) begin
          vecs++; if (cyc - last_rsp_cyc != 2) begin errs++; $display("FAIL back_to_back_gap: got %0d expected 2", cyc - last_rsp_cyc); end
        end
        last_g = g;
        ngnt++;
        if (ngnt == 4) bus.req = 2'b00;
      end
      if (bus.rsp_valid !== 2'b00) begin
        exp_rv = (last_g == 0) ? 2'b01 : 2'b10;
        vecs++; if (bus.rsp_valid !== exp_rv) begin errs++; $display("FAIL contention_route: got %b expected %b", bus.rsp_valid, exp_rv); end
        vecs++; if (bus.rsp_result !== 16'hFFFD) begin errs++; $display("FAIL contention_result: got %h expected FFFD", bus.rsp_result); end
        last_rsp_cyc = cyc;
        nrsp++;
      end
    end
    vecs++; if (ngnt != 4 || nrsp != 4) begin errs++; $display("FAIL contention_count: got %0d grants %0d responses expected 4 and 4", ngnt, nrsp); end
    step();
  endtask

  task automatic test_timeout();
    int starts = 0;
    bus.req_op = {3'b000, 3'b010}; bus.req_a = {8'd0, 8'd3}; bus.req_b = {8'd0, 8'd4};
    model_k = 0;
    bus.req = 2'b01;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (bus.alu_start === 1'b1) starts++;
      vecs++; if (bus.gnt !== (i == 1 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL timeout_gnt c%0d: got %b expected %b", i, bus.gnt, (i == 1 ? 2'b01 : 2'b00)); end
      vecs++; if (bus.rsp_valid !== (i == 18 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL timeout_rsp_valid c%0d: got %b expected %b", i, bus.rsp_valid, (i == 18 ? 2'b01 : 2'b00)); end
      vecs++; if (bus.busy !== (i <= 18)) begin errs++; $display("FAIL timeout_busy c%0d: got %b expected %b", i, bus.busy, (i <= 18)); end
      if (i == 18) begin
        vecs++; if (bus.rsp_err !== 1'b1) begin errs++; $display("FAIL timeout_err: got %b expected 1", bus.rsp_err); end
        vecs++; if (bus.rsp_result !== 16'h0000) begin errs++; $display("FAIL timeout_result: got %h expected 0000", bus.rsp_result); end
      end
      if (i == 1) bus.req = 2'b00;
      if (i == 20) begin
        bus.alu_done = 1'b1;
        bus.alu_result = 16'hDEAD;
      end
    end
    vecs++; if (starts != 1) begin errs++; $display("FAIL timeout_start_cycles: got %0d expected 1", starts); end
    bus.req_op = {3'b000, 3'b000}; bus.req_a = {8'd0, 8'd1}; bus.req_b = {8'd0, 8'd1};
    model_k = 1; model_res = 16'h0002;
    bus.req = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      step();
      vecs++; if (bus.gnt !== (i == 1 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL after_timeout_gnt c%0d: got %b expected %b", i, bus.gnt, (i == 1 ? 2'b01 : 2'b00)); end
      vecs++; if (bus.rsp_valid !== (i == 3 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL after_timeout_rsp_valid c%0d: got %b expected %b", i, bus.rsp_valid, (i == 3 ? 2'b01 : 2'b00)); end
      if (i == 3) begin
        vecs++; if ({bus.rsp_err, bus.rsp_result} !== {1'b0, 16'h0002}) begin errs++; $display("FAIL after_timeout_rsp: got err %b result %h expected err 0 result 0002", bus.rsp_err, bus.rsp_result); end
      end
      if (i == 1) bus.req = 2'b00;
    end
  endtask

  task automatic test_tie();
    bus.req_op = {3'b000, 3'b011}; bus.req_a = {8'd0, 8'd4}; bus.req_b = {8'd0, 8'd6};
    model_k = TIMEOUT; model_res = 16'h000A;
    bus.req = 2'b01;
    for (int i = 1; i <= 19; i++) begin
      step();
      vecs++; if (bus.rsp_valid !== (i == 18 ? 2'b01 : 2'b00)) begin errs++; $display("FAIL tie_rsp_valid c%0d: got %b expected %b", i, bus.rsp_valid, (i == 18 ? 2'b01 : 2'b00)); end
      if (i == 18) begin
        vecs++; if (bus.rsp_err !== 1'b0) begin errs++; $display("FAIL tie_err: got %b expected 0", bus.rsp_err); end
        vecs++; if (bus.rsp_result !== 16'h000A) begin errs++; $display("FAIL tie_result: got %h expected 000A", bus.rsp_result); end
      end
      if (i == 1) bus.req = 2'b00;
    end
  endtask

  task automatic test_reset_wait();
    bus.req_op = {3'b000, 3'b000}; bus.req_a = {8'd0, 8'd1}; bus.req_b = {8'd0, 8'd1};
    model_k = 10; model_res = 16'h0055;
    bus.req = 2'b01;
    step();
    vecs++; if (bus.alu_start !== 1'b1) begin errs++; $display("FAIL rstwait_start: got %b expected 1", bus.alu_start); end
    bus.req = 2'b00;
    step(); step();
    reset = 1'b1;
    cd = 0;
    #1;
    vecs++; if ({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.alu_start, bus.busy} !== 7'b0) begin errs++; $display("FAIL rstwait_ctrl: got %b expected 0000000", {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.alu_start, bus.busy}); end
    vecs++; if ({bus.rsp_result, bus.alu_op, bus.alu_a, bus.alu_b} !== 35'h0) begin errs++; $display("FAIL rstwait_data: got %h expected 0", {bus.rsp_result, bus.alu_op, bus.alu_a, bus.alu_b}); end
    step(); step();
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      vecs++; if (bus.rsp_valid !== 2'b00) begin errs++; $display("FAIL rstwait_no_rsp c%0d: got %b expected 00", i, bus.rsp_valid); end
    end
    bus.req_op = {3'b000, 3'b000}; bus.req_a = {8'd3, 8'd1}; bus.req_b = {8'd3, 8'd1};
    model_k = 1; model_res = 16'h0002;
    bus.req = 2'b11;
    step();
    vecs++; if (bus.gnt !== 2'b01) begin errs++; $display("FAIL rstwait_priority: got %b expected 01", bus.gnt); end
    bus.req = 2'b00;
    step(); step();
    vecs++; if (bus.rsp_valid !== 2'b01) begin errs++; $display("FAIL rstwait_rsp_after: got %b expected 01", bus.rsp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_contention();
    test_timeout();
    test_tie();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
